// File: rtl/stall_data_mem_if.sv
// Request/response bundle between the MEM-stage initiator and stall_data_mem.
interface stall_data_mem_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
  logic        err;

  modport master (output Addr, DataIn, Rd, Wr, input DataOut, Stall, Done, err);
  modport slave  (input Addr, DataIn, Rd, Wr, output DataOut, Stall, Done, err);
endinterface

// File: rtl/stall_data_mem.sv
// Multi-cycle data memory for the MEM stage: one request at a time, Stall while busy,
// Done pulse LATENCY cycles after the request. Optional macro: SDM_ALIGN_CHECK_EN.
module stall_data_mem #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 9
) (
  input logic             clk,
  input logic             rst,
  stall_data_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int         WORDS        = 1 << (ADDR_W - 1);
  localparam logic [3:0] CNT_LOAD     = 4'(LATENCY - 1);
  localparam state_t     ACCEPT_STATE = (LATENCY == 1) ? DONE : BUSY;

  state_t            state_q, state_d;
  logic [15:0]       mem [WORDS];
  logic [ADDR_W-2:0] idx_q;
  logic [15:0]       data_q;
  logic              wr_q;
  logic [3:0]        cnt_q;
  logic              err_q;

  logic        illegal, misalign, req, sample, accept;
  logic        stall, done;
  logic [15:0] dout;
  logic        unused_addr;

  assign illegal = bus.Rd & bus.Wr;
`ifdef SDM_ALIGN_CHECK_EN
  assign misalign = (bus.Rd ^ bus.Wr) & bus.Addr[0];
`else
  assign misalign = 1'b0;
`endif
  assign req    = (bus.Rd ^ bus.Wr) & ~misalign;
  assign sample = (state_q == IDLE) || (state_q == DONE);
  assign accept = sample & req;

  // Upper address bits wrap and Addr[0] is a byte offset inside the word.
  assign unused_addr = ^{bus.Addr[15:ADDR_W], bus.Addr[0]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    dout    = 16'h0000;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = ACCEPT_STATE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!wr_q) dout = mem[idx_q];
        if (req) begin
          stall   = 1'b1;
          state_d = ACCEPT_STATE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing can be accepted while reset is asserted, so never stall the pipeline then.
    stall = stall & rst;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      data_q <= 16'h0000;
      wr_q   <= 1'b0;
      cnt_q  <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        idx_q  <= bus.Addr[ADDR_W-1:1];
        data_q <= bus.DataIn;
        wr_q   <= bus.Wr;
        cnt_q  <= CNT_LOAD;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (sample & (illegal | misalign)) err_q <= 1'b1;
    end
  end

  // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 16'h0000;
    end else if (state_q == DONE && wr_q) begin
      mem[idx_q] <= data_q;
    end
  end

  assign bus.DataOut = dout;
  assign bus.Stall   = stall;
  assign bus.Done    = done;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_stall_data_mem.sv
// Directed and randomized checks of stall_data_mem against a word-array reference model.
module tb_stall_data_mem;

  localparam int L      = 4;
  localparam int ADDR_W = 9;
  localparam int WORDS  = 1 << (ADDR_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] mem_model [WORDS];
  logic        exp_err;

  stall_data_mem_if bus ();

  stall_data_mem #(.LATENCY(L), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [15:0] a);
    return (int'(a) % (1 << ADDR_W)) / 2;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    bus.Addr = 16'h0000;
    bus.DataIn = 16'h0000;
  endtask

  task automatic clear_model();
    for (int i = 0; i < WORDS; i++) mem_model[i] = 16'h0000;
    exp_err = 1'b0;
  endtask

  // Starts in a cycle where the DUT can accept; returns in the Done cycle when chained.
  task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [15:0] data, input bit chain);
    bus.Rd = rd;
    bus.Wr = wr;
    bus.Addr = addr;
    bus.DataIn = data;
    #1;
    check("stall_req", 16'(bus.Stall), 16'h1);
    for (int i = 1; i < L; i++) begin
      step();
      check("stall_busy", 16'(bus.Stall), 16'h1);
      check("done_busy", 16'(bus.Done), 16'h0);
      check("dout_busy", bus.DataOut, 16'h0000);
    end
    step();
    check("done_pulse", 16'(bus.Done), 16'h1);
    check("err_done", 16'(bus.err), 16'(exp_err));
    if (rd) check("rdata", bus.DataOut, mem_model[widx(addr)]);
    else    mem_model[widx(addr)] = data;
    if (!chain) begin
      idle_inputs();
      #1;
      check("stall_idle", 16'(bus.Stall), 16'h0);
      step();
      check("done_clear", 16'(bus.Done), 16'h0);
      check("dout_idle", bus.DataOut, 16'h0000);
    end
  endtask

  initial begin
    idle_inputs();
    clear_model();

    #3;
    check("rst_stall", 16'(bus.Stall), 16'h0);
    check("rst_done", 16'(bus.Done), 16'h0);
    check("rst_dout", bus.DataOut, 16'h0000);
    check("rst_err", 16'(bus.err), 16'h0);
    #9 rst = 1'b1;
    step();

    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    check("beef_model", mem_model[widx(16'h0010)], 16'hBEEF);

    txn(1'b0, 1'b1, 16'h0002, 16'h1234, 1'b1);
    txn(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);

    txn(1'b0, 1'b1, 16'h0200, 16'h5555, 1'b0);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

`ifdef SDM_ALIGN_CHECK_EN
    bus.Rd = 1'b1;
    bus.Addr = 16'h0003;
    #1;
    check("align_stall", 16'(bus.Stall), 16'h0);
    step();
    exp_err = 1'b1;
    check("align_err", 16'(bus.err), 16'(exp_err));
    check("align_done", 16'(bus.Done), 16'h0);
    idle_inputs();
    for (int i = 0; i < L + 1; i++) begin
      step();
      check("align_no_done", 16'(bus.Done), 16'h0);
    end
`else
    txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
`endif

    bus.Rd = 1'b1;
    bus.Wr = 1'b1;
    bus.Addr = 16'h0000;
    #1;
    check("illegal_stall", 16'(bus.Stall), 16'h0);
    step();
    exp_err = 1'b1;
    check("illegal_err", 16'(bus.err), 16'(exp_err));
    idle_inputs();
    for (int i = 0; i < L + 1; i++) begin
      step();
      check("illegal_no_done", 16'(bus.Done), 16'h0);
      check("err_sticky", 16'(bus.err), 16'h1);
    end

    bus.Wr = 1'b1;
    bus.Addr = 16'h0004;
    bus.DataIn = 16'hAAAA;
    #1;
    check("abort_stall_req", 16'(bus.Stall), 16'h1);
    step();
    check("abort_busy", 16'(bus.Stall), 16'h1);
    #2 rst = 1'b0;
    #1;
    clear_model();
    check("abort_done", 16'(bus.Done), 16'h0);
    check("abort_stall", 16'(bus.Stall), 16'h0);
    check("abort_err", 16'(bus.err), 16'(exp_err));
    step();
    idle_inputs();
    #4 rst = 1'b1;
    step();
    txn(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    for (int n = 0; n < 40; n++) begin
      bit          is_rd;
      bit          chain;
      logic [15:0] addr;
      int          w;
      int          lsb;
      is_rd = 1'($urandom_range(0, 1));
      chain = (n != 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      w     = int'($urandom_range(0, 7));
`ifdef SDM_ALIGN_CHECK_EN
      lsb   = 0;
`else
      lsb   = int'($urandom_range(0, 1));
`endif
      addr  = 16'((int'($urandom_range(0, 127)) << ADDR_W) | (w << 1) | lsb);
      txn(is_rd, ~is_rd, addr, 16'($urandom), chain);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
